gcd_unit: RTL and testbench

- Sequential GCD engine sitting directly downstream of the Sel/CarryIn edge-detect logic in top.
- Consumes the GCD_Load one-cycle pulse and the two keypad operands, key_value_a and key_value_b.
- Computes gcd(A,B) by iterative subtractive Euclid, one step per lcdclk.
- Presents the result, with done and busy flags, to the LCD/display path alongside the ALU result.

---
 rtl/gcd_unit.sv | 104 ++++++++++
 tb/tb_gcd_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_unit.sv
// Sequential subtractive-Euclid GCD engine: one subtraction per lcdclk edge,
// latched operands, level/pulse completion flags and a step counter.
module gcd_unit #(
    parameter int WIDTH = 12
) (
    input  logic             lcdclk,
    input  logic             reset,
    input  logic             GCD_Load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] gcd_out,
    output logic             done,
    output logic             done_pulse,
    output logic             busy,
    output logic [WIDTH-1:0] iter_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] gcd_q;
    logic [WIDTH-1:0] iter_q;
    logic             done_q;
    logic             done_pulse_q;
    logic             busy_q;

    logic             terminal_d;
    logic             a_gt_b_d;
    logic [WIDTH-1:0] ra_d;
    logic [WIDTH-1:0] rb_d;

    // Always larger minus smaller, so neither register can underflow.
    always_comb begin
        terminal_d = (ra_q == '0) || (rb_q == '0) || (ra_q == rb_q);
        a_gt_b_d   = (ra_q > rb_q);
        ra_d       = ra_q;
        rb_d       = rb_q;
        if (a_gt_b_d) begin
            ra_d = ra_q - rb_q;
        end else begin
            rb_d = rb_q - ra_q;
        end
    end

    always_ff @(posedge lcdclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ra_q         <= '0;
            rb_q         <= '0;
            gcd_q        <= '0;
            iter_q       <= '0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (GCD_Load) begin
                        ra_q    <= A;
                        rb_q    <= B;
                        iter_q  <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // GCD_Load is deliberately ignored here; no request queuing.
                    if (terminal_d) begin
                        gcd_q        <= ra_q | rb_q;
                        done_q       <= 1'b1;
                        done_pulse_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= DONE;
                    end else begin
                        ra_q   <= ra_d;
                        rb_q   <= rb_d;
                        iter_q <= iter_q + WIDTH'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gcd_out    = gcd_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign busy       = busy_q;
    assign iter_cnt   = iter_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: directed and random operand pairs checked against a
// modulo-Euclid reference for the result, step count and completion latency.
module tb_gcd_unit;

    localparam int WIDTH = 12;
    localparam int MAX_WAIT = 5000;

    logic             lcdclk;
    logic             reset;
    logic             GCD_Load;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] gcd_out;
    logic             done;
    logic             done_pulse;
    logic             busy;
    logic [WIDTH-1:0] iter_cnt;
    logic [1:0]       state_o;

    int errors = 0;
    int checks = 0;

    gcd_unit #(.WIDTH(WIDTH)) dut (
        .lcdclk     (lcdclk),
        .reset      (reset),
        .GCD_Load   (GCD_Load),
        .A          (A),
        .B          (B),
        .gcd_out    (gcd_out),
        .done       (done),
        .done_pulse (done_pulse),
        .busy       (busy),
        .iter_cnt   (iter_cnt),
        .state_o    (state_o)
    );

    // clock / reset
    initial lcdclk = 1'b0;
    always #5 lcdclk = ~lcdclk;

    // Reference: gcd via modulo Euclid.
    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtractive step count = sum of Euclid quotients minus the final one
    // that the equality test short-circuits; zero if either operand is zero.
    function automatic int ref_iters(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        int sum = 0;
        if (a == 0 || b == 0) return 0;
        while (y != 0) begin
            sum += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return sum - 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver: one-cycle load pulse; returns at the negedge after the load edge.
    task automatic start_load(input int a, input int b, input string tag);
        @(negedge lcdclk);
        A = WIDTH'(a);
        B = WIDTH'(b);
        GCD_Load = 1'b1;
        @(negedge lcdclk);
        GCD_Load = 1'b0;
        check({tag, " busy_after_load"}, int'(busy), 1);
        check({tag, " done_after_load"}, int'(done), 0);
    endtask

    // Waits for done; cnt counts load-relative edges already elapsed.
    task automatic wait_done(input int a, input int b, input int offset, input string tag);
        int cnt = offset;
        int n = ref_iters(a, b);
        while (done !== 1'b1 && cnt < MAX_WAIT) begin
            @(negedge lcdclk);
            cnt++;
        end
        check({tag, " latency"}, cnt, n + 1);
        check({tag, " gcd_out"}, int'(gcd_out), ref_gcd(a, b));
        check({tag, " iter_cnt"}, int'(iter_cnt), n);
        check({tag, " done_pulse_rise"}, int'(done_pulse), 1);
        check({tag, " busy_at_done"}, int'(busy), 0);
        @(negedge lcdclk);
        check({tag, " done_pulse_drop"}, int'(done_pulse), 0);
        check({tag, " done_hold"}, int'(done), 1);
    endtask

    initial begin
        int ra;
        int rb;
        reset = 1'b1;
        GCD_Load = 1'b0;
        A = '0;
        B = '0;
        @(negedge lcdclk);
        check("reset gcd_out", int'(gcd_out), 0);
        check("reset done", int'(done), 0);
        check("reset done_pulse", int'(done_pulse), 0);
        check("reset busy", int'(busy), 0);
        check("reset iter_cnt", int'(iter_cnt), 0);
        check("reset state_idle", int'(state_o), 0);
        reset = 1'b0;

        start_load(12, 8, "g12_8");
        wait_done(12, 8, 0, "g12_8");

        start_load(4095, 1, "g4095_1");
        wait_done(4095, 1, 0, "g4095_1");
        start_load(1, 4095, "g1_4095");
        wait_done(1, 4095, 0, "g1_4095");

        start_load(0, 9, "g0_9");
        wait_done(0, 9, 0, "g0_9");
        start_load(9, 0, "g9_0");
        wait_done(9, 0, 0, "g9_0");
        start_load(0, 0, "g0_0");
        wait_done(0, 0, 0, "g0_0");

        // Mid-computation operand change and load must be ignored.
        start_load(2048, 768, "g2048_768");
        @(negedge lcdclk);
        A = 12'd5;
        B = 12'd3;
        GCD_Load = 1'b1;
        @(negedge lcdclk);
        GCD_Load = 1'b0;
        check("g2048_768 busy_mid", int'(busy), 1);
        wait_done(2048, 768, 2, "g2048_768");

        start_load(17, 17, "g17_17");
        check("g17_17 gcd_hold_old", int'(gcd_out), 256);
        wait_done(17, 17, 0, "g17_17");

        // Asynchronous reset in the middle of a long computation.
        start_load(4095, 1, "abort");
        repeat (100) @(negedge lcdclk);
        #2 reset = 1'b1;
        #1;
        check("abort gcd_out", int'(gcd_out), 0);
        check("abort done", int'(done), 0);
        check("abort done_pulse", int'(done_pulse), 0);
        check("abort busy", int'(busy), 0);
        check("abort iter_cnt", int'(iter_cnt), 0);
        check("abort state_idle", int'(state_o), 0);
        @(negedge lcdclk);
        reset = 1'b0;
        start_load(21, 14, "g21_14");
        wait_done(21, 14, 0, "g21_14");

        // GCD_Load held high: restart every (n+2) edges, done one cycle each.
        @(negedge lcdclk);
        A = 12'd6;
        B = 12'd4;
        GCD_Load = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge lcdclk);
            check($sformatf("held done c%0d", c), int'(done),
                  ((c % (ref_iters(6, 4) + 2)) == ref_iters(6, 4) + 1) ? 1 : 0);
            check($sformatf("held pulse c%0d", c), int'(done_pulse), int'(done));
            if (done === 1'b1) check($sformatf("held gcd c%0d", c), int'(gcd_out), 2);
        end
        GCD_Load = 1'b0;
        wait_done(6, 4, 0, "held_tail");

        // Random operand pairs against the reference model.
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = $urandom_range(0, 4095);
                rb = $urandom_range(0, 4095);
            end else begin
                ra = $urandom_range(0, 255);
                rb = $urandom_range(0, 255);
            end
            start_load(ra, rb, $sformatf("rnd%0d", k));
            wait_done(ra, rb, 0, $sformatf("rnd%0d(%0d,%0d)", k, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
